conv_stream_source: RTL and testbench
=====================================

// Module: conv_stream_source
// PURPOSE
//  AXI-Stream master that feeds the 2D convolution engine: emits the 9-word filter packet, then the image-data packet.
//  Host loads coefficients and image words through a simple write port into an internal buffer, then pulses start.
//  Sits between the host/config side and the conv engine's S_AXIS input; streams at one word per cycle under backpressure.
// PARAMETERS
//  DATA_W     16    word width of TDATA and of buffer entries
//  FILT_LEN   9     filter coefficients per filter packet (3x3)
//  MAX_WORDS  1024  data-buffer depth in words
//  ADDR_W     10    buffer address width, equal to clog2(MAX_WORDS)
// PORTS
//  M_AXIS_ACLK     in   1          single clock for all logic
//  M_AXIS_ARESETN  in   1          asynchronous, active-low reset
//  wr_en           in   1          buffer write strobe
//  wr_sel          in   1          0 = filter buffer, 1 = data buffer
//  wr_addr         in   ADDR_W     write address; filter uses low 4 bits only
//  wr_data         in   DATA_W     write data
//  data_len        in   ADDR_W+1   number of data words to send; sampled on accepted start
//  start           in   1          single-cycle pulse that launches one transfer
//  busy            out  1          high from accepted start until the final beat handshakes
//  done            out  1          one-cycle pulse after the final data beat handshakes
//  cfg_err         out  1          one-cycle pulse when start is rejected
//  M_AXIS_TVALID   out  1          output beat valid
//  M_AXIS_TDATA    out  DATA_W     output beat payload
//  M_AXIS_TKEEP    out  2          constant 2'b11
//  M_AXIS_TLAST    out  1          high on the last beat of each packet
//  M_AXIS_TREADY   in   1          downstream ready
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; TVALID, TLAST, busy, done, cfg_err = 0; TDATA = 0; counters = 0.
//  Buffer contents are not reset.
//  States: IDLE -> FILT -> DATA -> IDLE.
//  IDLE: start with 3 <= data_len <= MAX_WORDS is accepted; latch data_len, set busy, go to FILT.
//   - start with any other data_len: stay in IDLE, pulse cfg_err the next cycle, do not assert busy.
//  FILT: send filter[0..FILT_LEN-1] in address order. TLAST on beat FILT_LEN-1. When that beat handshakes, go to DATA.
//  DATA: send data[0..len-1]. TLAST on beat len-1. When that beat handshakes, go to IDLE, clear busy, pulse done.
//  Handshake: a beat transfers on TVALID && TREADY.
//   - Once TVALID is high, TDATA and TLAST hold stable until the handshake.
//   - TVALID never drops without a handshake.
//  Latency: accepted start at edge k -> TVALID high after edge k+2 (synchronous-read buffer).
//  Throughput: with TREADY held high, one beat per cycle.
//   - No bubble between the filter and data packets, or inside either packet.
//   - This requires read-ahead plus a 2-entry output skid.
//  TREADY toggling arbitrarily: no beat is lost or duplicated, and order is preserved.
//  start while busy: ignored, with no cfg_err.
//  wr_en while busy: ignored, so the buffer is frozen during streaming. wr_en in IDLE is a one-cycle write.
//  wr_en and start in the same IDLE cycle: the write completes, and the transfer sees the new value.
//  done and the final-beat handshake: done is asserted on the cycle after that handshake. A new start is accepted on that same cycle.
//  Reset mid-transfer: TVALID drops immediately (async); the stream is truncated; after release the block is in IDLE.
//  Counters: filter index counts to FILT_LEN-1; data index wraps to 0 at len-1. No arithmetic overflow is possible for data_len <= MAX_WORDS.
// STRUCTURE
//  Shared package conv_pkg: DATA_W, FILT_LEN, and state encoding (IDLE=2'd0, FILT=2'd1, DATA=2'd2).
//   - The conv engine and this source use the same package.
//  Sub-module conv_src_ram: simple dual-port RAM with synchronous read and one write port.
//   - Instantiated twice: FILT_LEN x DATA_W and MAX_WORDS x DATA_W.
//  The top level holds the FSM, read-address counters, and the 2-entry output skid.
// TESTING
//  1. Load filter 1..9 and data 10..18, data_len=9, TREADY=1.
//     -> 18 consecutive beats 1..18; TLAST on beats 9 and 18; done 1 cycle after beat 18; busy high for 20 cycles.
//  2. Same stimulus, with TREADY pattern 1,0,0,1 repeating.
//     -> identical beat sequence; TDATA stable across every stall; no lost or duplicated beats.
//  3. start with data_len=2, then data_len=MAX_WORDS+1.
//     -> cfg_err pulses twice; busy stays 0; TVALID stays 0.
//  4. While busy, issue wr_en to data[0] with 16'hFFFF and pulse start.
//     -> stream unchanged (data[0] sent as 10); no restart; no cfg_err.
//  5. Deassert M_AXIS_ARESETN after 5 beats of test 1.
//     -> TVALID=0 immediately; after release a fresh start resends from filter[0] with TLAST=1 on beat 9.
//  6. Pulse start in the same cycle as done, with data_len=3.
//     -> a second transfer begins; 12 beats with TLAST on beats 9 and 12.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 2D convolution engine and its stream source.
package conv_pkg;

  localparam int unsigned CONV_DATA_W    = 16;
  localparam int unsigned CONV_FILT_LEN  = 9;
  localparam int unsigned CONV_MAX_WORDS = 1024;
  localparam int unsigned CONV_ADDR_W    = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFilt = 2'd1,
    StData = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_src_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, contents not reset.
module conv_src_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_stream_source.sv
// AXI-Stream source for the conv engine: a filter packet followed by an image-data packet,
// read ahead from local buffers through a 2-entry output skid.
module conv_stream_source
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W    = CONV_DATA_W,
  parameter int unsigned FILT_LEN  = CONV_FILT_LEN,
  parameter int unsigned MAX_WORDS = CONV_MAX_WORDS,
  parameter int unsigned ADDR_W    = CONV_ADDR_W
) (
  input  logic              M_AXIS_ACLK,
  input  logic              M_AXIS_ARESETN,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   data_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic [1:0]        M_AXIS_TKEEP,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY
);

  localparam int unsigned FiltAw = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned LenW   = ADDR_W + 1;

  conv_state_e       r_state, w_state_nxt;
  logic              w_idle, w_len_ok, w_start_ok, w_start_bad, w_wr_ok, w_filt_we;
  logic              w_pop, w_issue, w_issue_last;
  logic [1:0]        w_cnt_after;
  logic              r_rd_act, r_rd_sel, r_rd_vld, r_rd_src, r_rd_last;
  logic [FiltAw-1:0] r_fidx;
  logic [ADDR_W-1:0] r_didx, r_last_idx;
  logic [DATA_W-1:0] w_filt_rdata, w_data_rdata, w_rd_data;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic              r_out_last, r_skid_last, r_done, r_cfg_err;

  assign w_idle      = (r_state == StIdle);
  assign w_len_ok    = (data_len >= LenW'(3)) && (data_len <= LenW'(MAX_WORDS));
  assign w_start_ok  = start && w_idle && w_len_ok;
  assign w_start_bad = start && w_idle && !w_len_ok;
  assign w_wr_ok     = wr_en && w_idle;
  assign w_filt_we   = w_wr_ok && !wr_sel &&
                       ({1'b0, wr_addr[FiltAw-1:0]} < (FiltAw + 1)'(FILT_LEN));

  // Credit: issue a read only if the skid can still absorb it next cycle.
  assign w_pop        = (r_cnt != 2'd0) && M_AXIS_TREADY;
  assign w_cnt_after  = r_cnt + 2'(r_rd_vld) - 2'(w_pop);
  assign w_issue      = r_rd_act && (w_cnt_after < 2'd2);
  assign w_issue_last = r_rd_sel ? (r_didx == r_last_idx) : (r_fidx == FiltAw'(FILT_LEN - 1));
  assign w_rd_data    = r_rd_src ? w_data_rdata : w_filt_rdata;

  conv_src_ram #(.DEPTH(FILT_LEN), .WIDTH(DATA_W), .AW(FiltAw)) u_filt_ram (
    .i_clk   (M_AXIS_ACLK),
    .i_we    (w_filt_we),
    .i_waddr (wr_addr[FiltAw-1:0]),
    .i_wdata (wr_data),
    .i_re    (w_issue && !r_rd_sel),
    .i_raddr (r_fidx),
    .o_rdata (w_filt_rdata)
  );

  conv_src_ram #(.DEPTH(MAX_WORDS), .WIDTH(DATA_W), .AW(ADDR_W)) u_data_ram (
    .i_clk   (M_AXIS_ACLK),
    .i_we    (w_wr_ok && wr_sel),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_re    (w_issue && r_rd_sel),
    .i_raddr (r_didx),
    .o_rdata (w_data_rdata)
  );

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_nxt = StFilt;
      StFilt:  if (w_pop && r_out_last) w_state_nxt = StData;
      StData:  if (w_pop && r_out_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy          = !w_idle;
    done          = r_done;
    cfg_err       = r_cfg_err;
    M_AXIS_TVALID = (r_cnt != 2'd0);
    M_AXIS_TDATA  = r_out_data;
    M_AXIS_TLAST  = r_out_last && (r_cnt != 2'd0);
    M_AXIS_TKEEP  = 2'b11;
  end

  // Read side runs ahead of the output beats, so it keeps its own phase and counters.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_rd_act   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_fidx     <= '0;
      r_didx     <= '0;
      r_last_idx <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_src   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_rd_vld  <= w_issue;
      r_rd_src  <= r_rd_sel;
      r_rd_last <= w_issue_last;
      r_done    <= (r_state == StData) && w_pop && r_out_last;
      r_cfg_err <= w_start_bad;
      if (w_start_ok) begin
        r_rd_act   <= 1'b1;
        r_rd_sel   <= 1'b0;
        r_fidx     <= '0;
        r_didx     <= '0;
        r_last_idx <= ADDR_W'(data_len - LenW'(1));
      end else if (w_issue) begin
        if (!r_rd_sel) begin
          if (w_issue_last) begin
            r_rd_sel <= 1'b1;
            r_fidx   <= '0;
          end else begin
            r_fidx <= r_fidx + FiltAw'(1);
          end
        end else begin
          if (w_issue_last) begin
            r_rd_act <= 1'b0;
            r_didx   <= '0;
          end else begin
            r_didx <= r_didx + ADDR_W'(1);
          end
        end
      end
    end
  end

  // Two-entry skid: r_out is the head driving the bus, r_skid the overflow slot.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_cnt       <= 2'd0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
    end else begin
      r_cnt <= w_cnt_after;
      if (w_pop || (r_cnt == 2'd0)) begin
        if (r_cnt == 2'd2) begin
          r_out_data <= r_skid_data;
          r_out_last <= r_skid_last;
          if (r_rd_vld) begin
            r_skid_data <= w_rd_data;
            r_skid_last <= r_rd_last;
          end
        end else if (r_rd_vld) begin
          r_out_data <= w_rd_data;
          r_out_last <= r_rd_last;
        end
      end else if (r_rd_vld) begin
        r_skid_data <= w_rd_data;
        r_skid_last <= r_rd_last;
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_source.sv
// Directed bench for conv_stream_source with a beat scoreboard and stall-stability checks.
module tb_conv_stream_source;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, tready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   data_len = '0;
  logic          busy, done, cfg_err, tvalid, tlast;
  logic [DW-1:0] tdata;
  logic [1:0]    tkeep;

  always #5 clk = ~clk;

  conv_stream_source dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .data_len       (data_len),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TKEEP   (tkeep),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] filt_m[9];
  logic [DW-1:0] data_m[1024];
  int beats, busy_cycles, done_cnt, cfg_cnt, tv_cnt;
  int first_beat_cyc, last_beat_cyc, done_cyc, start_cyc;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    beats = 0; busy_cycles = 0; done_cnt = 0; cfg_cnt = 0; tv_cnt = 0;
    first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
  endtask

  // Observe the current cycle (inputs already driven), then advance one clock.
  task automatic tick();
    logic [DW:0] e;
    if (prev_stall) begin
      chk("hold_valid", 32'(tvalid), 1);
      chk("hold_data", 32'(tdata), 32'(prev_data));
      chk("hold_last", 32'(tlast), 32'(prev_last));
    end
    if (tvalid && tready) begin
      beats++;
      if (beats == 1) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", {tlast, tdata});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 32'({tlast, tdata}), 32'(e));
      end
    end
    if (busy) busy_cycles++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) cfg_cnt++;
    if (tvalid) tv_cnt++;
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DW-1:0] val, input bit model);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = val;
    if (model) begin
      if (sel) data_m[addr] = val;
      else filt_m[addr] = val;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_xfer(input int len);
    for (int i = 0; i < 9; i++) exp_q.push_back({1'(i == 8), filt_m[i]});
    for (int i = 0; i < len; i++) exp_q.push_back({1'(i == len - 1), data_m[i]});
  endtask

  task automatic start_xfer(input int len, input bit accept);
    data_len = (AW + 1)'(len);
    start = 1'b1;
    if (accept) push_xfer(len);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_until_done(input int budget, input int mode, input int target);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      tready = ready_for(mode, cyc);
      tick();
    end
    chk("done_seen", done_cnt, target);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("tkeep", 32'(tkeep), 3);

    for (int i = 0; i < 9; i++) wr(1'b0, i, DW'(i + 1), 1'b1);
    for (int i = 0; i < 9; i++) wr(1'b1, i, DW'(i + 10), 1'b1);

    // 1: full throughput
    clr(); tready = 1'b1;
    start_xfer(9, 1'b1);
    run_until_done(100, 0, 1);
    chk("t1_beats", beats, 18);
    chk("t1_latency", first_beat_cyc - start_cyc, 3);
    chk("t1_no_bubble", last_beat_cyc - first_beat_cyc, 17);
    chk("t1_done_time", done_cyc, last_beat_cyc + 1);
    chk("t1_busy_cycles", busy_cycles, 20);
    chk("t1_drained", exp_q.size(), 0);

    // 2: backpressure pattern 1,0,0,1
    clr();
    start_xfer(9, 1'b1);
    run_until_done(200, 1, 1);
    chk("t2_beats", beats, 18);
    chk("t2_drained", exp_q.size(), 0);
    tready = 1'b1;

    // 3: rejected starts
    clr();
    start_xfer(2, 1'b0);
    chk("t3_cfg_err_a", 32'(cfg_err), 1);
    tick();
    chk("t3_cfg_err_clr", 32'(cfg_err), 0);
    start_xfer(1025, 1'b0);
    chk("t3_cfg_err_b", 32'(cfg_err), 1);
    repeat (4) tick();
    chk("t3_cfg_cnt", cfg_cnt, 2);
    chk("t3_busy", busy_cycles, 0);
    chk("t3_tvalid", tv_cnt, 0);

    // 4: write and start while busy are ignored
    clr();
    start_xfer(9, 1'b1);
    repeat (3) tick();
    wr(1'b1, 0, 16'hFFFF, 1'b0);
    start_xfer(9, 1'b0);
    chk("t4_no_cfg_err", 32'(cfg_err), 0);
    run_until_done(100, 0, 1);
    repeat (5) tick();
    chk("t4_beats", beats, 18);
    chk("t4_cfg_cnt", cfg_cnt, 0);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_drained", exp_q.size(), 0);

    // 5: reset mid-transfer
    clr();
    start_xfer(9, 1'b1);
    for (int i = 0; i < 50 && beats < 5; i++) tick();
    chk("t5_five_beats", beats, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tvalid_async", 32'(tvalid), 0);
    chk("t5_busy_async", 32'(busy), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();
    start_xfer(9, 1'b1);
    run_until_done(100, 0, 1);
    chk("t5_beats", beats, 18);
    chk("t5_drained", exp_q.size(), 0);

    // 6: start on the done cycle
    clr();
    start_xfer(9, 1'b1);
    for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
    chk("t6_done_now", 32'(done), 1);
    start_xfer(3, 1'b1);
    chk("t6_busy_again", 32'(busy), 1);
    run_until_done(100, 0, 2);
    chk("t6_beats", beats, 30);
    chk("t6_drained", exp_q.size(), 0);

    // 7: full-depth transfer, write+start in the same cycle, random backpressure
    for (int i = 1; i < 1024; i++) wr(1'b1, i, DW'(i * 7 + 3), 1'b1);
    clr();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = 16'hBEEF;
    data_m[0] = 16'hBEEF;
    start_xfer(1024, 1'b1);
    wr_en = 1'b0;
    run_until_done(5000, 2, 1);
    chk("t7_beats", beats, 1033);
    chk("t7_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
